if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Owns the PC and issues sequential fetch addresses to the ROM over a valid/ready request.
- Captures the ROM's registered data, which returns one cycle after issue, into a small prefetch buffer.
- Presents instruction+PC pairs to decode with a valid/ready handshake and handles redirects (jump/branch/flush) from execute.

Parameters:
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, prefetch buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pc_o  out  ADDR_W  fetch address to ROM
- pc_send_valid_o  out  1  fetch request valid
- pc_receive_ready_i  in  1  ROM accepts request
- inst_data_i  in  DATA_W  ROM instruction, valid 1 cycle after accepted request
- inst_valid_i  in  1  ROM data valid qualifier
- jump_en_i  in  1  redirect request from execute
- jump_addr_i  in  ADDR_W  redirect target
- hold_i  in  1  pipeline hold; suppresses new issue only
- inst_o  out  DATA_W  instruction to decode
- inst_addr_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  decode-side valid
- inst_ready_i  in  1  decode accepts

Behaviour:
- Reset (rst=1, asynchronous):
  - pc_o=RESET_PC; pc_send_valid_o=0; inst_valid_o=0; inst_o=0; inst_addr_o=0.
  - Buffer empty; in-flight flag cleared; FSM=IDLE.
- FSM states:
  - IDLE: one cycle after reset deassertion → FETCH.
  - FETCH: normal issue.
  - REDIRECT: one-cycle bubble after jump, then → FETCH.
- Issue rule (FETCH): pc_send_valid_o=1 when !hold_i && (buf_count + inflight) < BUF_DEPTH.
- Request acceptance: a request is accepted when pc_send_valid_o && pc_receive_ready_i.
  - On acceptance: inflight←1, inflight_pc←pc_o, pc_o←pc_o+4 (modulo 2^ADDR_W; wrap-around is legal).
- Response capture: in the cycle after acceptance, if inflight && inst_valid_i, push {inflight_pc, inst_data_i} into the buffer.
  - inflight clears unless a new request was accepted in the same cycle.
  - Throughput: 1 instr/cycle when decode is always ready.
- Decode side:
  - inst_valid_o = buffer non-empty; inst_o/inst_addr_o = buffer head (fall-through).
  - Pop on inst_valid_o && inst_ready_i.
  - Simultaneous push and pop on a full buffer is legal; the count is unchanged.
- Redirect (jump_en_i=1, any state except IDLE):
  - Next cycle: buffer emptied; inflight response marked stale (the response arriving next cycle is dropped); pc_o←jump_addr_i; FSM→REDIRECT.
  - A decode pop in the same cycle as jump_en_i still completes.
  - jump_en_i has priority over issue; pc_send_valid_o=0 in the jump cycle.
- Back-to-back jumps: the latest target wins.
- hold_i: blocks issue only. Buffered instructions still drain, and in-flight data is still captured.
- Overflow is impossible by the credit rule. Assertion: no push when the buffer is full.
- Reset asserted mid-operation: all state returns to reset values immediately; any ROM response afterwards is ignored until FETCH.

Optional Feature:
- IF_MISALIGN_CHECK_EN
- Defined:
  - Adds output `misalign_o` (1 bit, reset 0).
  - A jump_addr_i with bits[1:0]≠0 sets misalign_o for one cycle.
  - The redirect is suppressed: PC is unchanged, but the buffer and inflight are still flushed.
- Undefined:
  - No port.
  - jump_addr_i is used verbatim.

Decomposition:
- Shared package/define file: ADDR_W/DATA_W defaults, ZeroWord, RESET_PC, INST_STEP (4), FSM state encodings.
- Sub-module: if_buf, a synchronous FIFO of {addr,data} with count output and flush input; BUF_DEPTH parameterized.

Test Plan:
- Reset release, ROM always ready, decode always ready → pc_o=0,4,8,…; inst_addr_o sequence 0,4,8 with one instr/cycle after 2-cycle latency.
- Decode inst_ready_i=0 for 5 cycles → buffer fills to 2; pc_send_valid_o drops; no instruction lost; order 0,4,8 preserved after release.
- jump_en_i=1, jump_addr_i=0x100, while a response to 0x0C is in flight → 0x0C never reaches decode; next inst_addr_o=0x100.
- pc_receive_ready_i low for 3 cycles → pc_o held; no duplicate or skipped PC.
- PC at 0xFFFF_FFFC → next pc_o=0x0000_0000.
- Feature on: jump_addr_i=0x102 → misalign_o pulses 1 cycle; pc_o unchanged; buffer empty.

Source files
------------

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared constants, defaults and FSM encoding for the
//            instruction-fetch stage (if_fetch, if_fetch_if, if_buf).
// Contents : ADDR_W/DATA_W defaults, ZeroWord, RESET_PC default,
//            INST_STEP, fetch_state_t.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam int          ADDR_W_DEFAULT   = 32;
  localparam int          DATA_W_DEFAULT   = 32;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_STEP        = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Purpose  : Bundle of the fetch stage's ROM request, ROM response,
//            redirect/hold control and decode-side handshake signals.
// Modports : master - the fetch stage (drives pc_*, inst_*_o)
//            slave  - the surrounding ROM / execute / decode environment
// Macro    : IF_MISALIGN_CHECK_EN adds misalign_o.
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic [ADDR_W-1:0] pc_o;
  logic              pc_send_valid_o;
  logic              pc_receive_ready_i;
  logic [DATA_W-1:0] inst_data_i;
  logic              inst_valid_i;
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
`ifdef IF_MISALIGN_CHECK_EN
  logic              misalign_o;
`endif

  modport master (
    output pc_o, pc_send_valid_o,
    input  pc_receive_ready_i, inst_data_i, inst_valid_i,
    input  jump_en_i, jump_addr_i, hold_i,
    output inst_o, inst_addr_o, inst_valid_o,
    input  inst_ready_i
`ifdef IF_MISALIGN_CHECK_EN
    , output misalign_o
`endif
  );

  modport slave (
    input  pc_o, pc_send_valid_o,
    output pc_receive_ready_i, inst_data_i, inst_valid_i,
    output jump_en_i, jump_addr_i, hold_i,
    input  inst_o, inst_addr_o, inst_valid_o,
    output inst_ready_i
`ifdef IF_MISALIGN_CHECK_EN
    , input misalign_o
`endif
  );

endinterface
`default_nettype wire

// File: rtl/if_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_buf
// Purpose  : Prefetch FIFO of {addr, data} pairs with fall-through head,
//            occupancy count and synchronous flush.
// Ports    : clk, rst (async, active-high), flush, push/push_addr/push_data,
//            pop, head_addr/head_data, empty, count.
// Revision : 1.0 - initial release
// ============================================================================
module if_buf
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int BUF_DEPTH = 2,
  localparam int PTR_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  input  wire logic              push,
  input  wire logic [ADDR_W-1:0] push_addr,
  input  wire logic [DATA_W-1:0] push_data,
  input  wire logic              pop,
  output logic      [ADDR_W-1:0] head_addr,
  output logic      [DATA_W-1:0] head_data,
  output logic                   empty,
  output logic      [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(BUF_DEPTH);

  logic [ADDR_W+DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     w_full;
  logic                     w_do_pop;
  logic                     w_do_push;

  assign w_full    = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign w_do_push = push && (!w_full || w_do_pop);

  assign {head_addr, head_data} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= {push_addr, push_data};
    end
  end

  // Pointers wrap naturally because BUF_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && w_full && !w_do_pop));
`endif

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage. Owns the PC, issues sequential fetch
//            requests to a registered ROM (data returns one cycle after
//            acceptance), buffers responses in if_buf and hands
//            {instruction, PC} pairs to decode. Handles execute redirects.
// Ports    : clk, rst (async, active-high), bus (if_fetch_if.master):
//            ROM request pc_o/pc_send_valid_o/pc_receive_ready_i,
//            ROM response inst_data_i/inst_valid_i, control jump_en_i/
//            jump_addr_i/hold_i, decode inst_o/inst_addr_o/inst_valid_o/
//            inst_ready_i.
// Macro    : IF_MISALIGN_CHECK_EN - flags jump targets with addr[1:0]!=0 on
//            misalign_o and keeps the PC instead of redirecting.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEFAULT,
  parameter int                DATA_W    = DATA_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                BUF_DEPTH = 2
) (
  input wire logic    clk,
  input wire logic    rst,
  if_fetch_if.master  bus
);

  localparam int             CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] c_depth = (CNT_W+1)'(BUF_DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              w_jump;
  logic              w_misalign;
  logic              w_issue;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_credit_used;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  // Redirects are ignored during the single post-reset IDLE cycle.
  assign w_jump = bus.jump_en_i && (r_state != ST_IDLE);

`ifdef IF_MISALIGN_CHECK_EN
  logic r_misalign;
  assign w_misalign = w_jump && (bus.jump_addr_i[1:0] != 2'b00);
  assign bus.misalign_o = r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_misalign;
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_pop  = !w_empty && bus.inst_ready_i;
  assign w_push = r_inflight && bus.inst_valid_i;

  // Credits: buffered entries plus the outstanding response, less the entry
  // decode takes this cycle. Counting the pop lets a depth-2 buffer sustain
  // one instruction per cycle while still never overflowing.
  assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}
                       - {{CNT_W{1'b0}}, w_pop};

  assign w_issue  = (r_state == ST_FETCH) && !w_jump && !bus.hold_i
                  && (w_credit_used < c_depth);
  assign w_accept = w_issue && bus.pc_receive_ready_i;

  assign bus.pc_o            = r_pc;
  assign bus.pc_send_valid_o = w_issue;
  assign bus.inst_valid_o    = !w_empty;
  assign bus.inst_o          = w_empty ? DATA_W'(ZeroWord) : w_head_data;
  assign bus.inst_addr_o     = w_empty ? ADDR_W'(ZeroWord) : w_head_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     w_state_nxt = ST_FETCH;
      ST_FETCH:    if (w_jump) w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: w_state_nxt = w_jump ? ST_REDIRECT : ST_FETCH;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // A jump drops the outstanding response by clearing the in-flight flag;
  // no request is issued in the jump cycle, so nothing else can return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (w_jump) begin
      r_inflight <= 1'b0;
      if (!w_misalign) r_pc <= bus.jump_addr_i;
    end else if (w_accept) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
      r_pc          <= r_pc + ADDR_W'(INST_STEP);
    end else begin
      r_inflight <= 1'b0;
    end
  end

  if_buf #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (w_jump),
    .push      (w_push),
    .push_addr (r_inflight_pc),
    .push_data (bus.inst_data_i),
    .pop       (w_pop),
    .head_addr (w_head_addr),
    .head_data (w_head_data),
    .empty     (w_empty),
    .count     (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Directed self-checking bench for if_fetch. A one-cycle
//            registered ROM model answers every accepted request with
//            addr ^ 32'hDEAD_BEEF. Inputs change and outputs are sampled on
//            the falling clock edge.
// Macro    : IF_MISALIGN_CHECK_EN enables the misaligned-jump scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        rom_valid;
  logic [31:0] rom_data;
  logic        force_valid;
  int          total;
  int          bad;

  if_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_valid <= 1'b0;
      rom_data  <= 32'h0;
    end else begin
      rom_valid <= bus.pc_send_valid_o && bus.pc_receive_ready_i;
      rom_data  <= rom_word(bus.pc_o);
    end
  end

  assign bus.inst_valid_i = rom_valid | force_valid;
  assign bus.inst_data_i  = rom_data;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    force_valid = 1'b0;
    bus.jump_en_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.hold_i = 1'b0;
    bus.pc_receive_ready_i = 1'b1;
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", bus.pc_o); end
    total++; if (bus.pc_send_valid_o !== 1'b0) begin bad++; $display("FAIL reset_send_valid: got %b want 0", bus.pc_send_valid_o); end
    total++; if ({bus.inst_valid_o, bus.inst_o, bus.inst_addr_o} !== 65'h0) begin bad++; $display("FAIL reset_decode: got v=%b i=%h a=%h want all 0", bus.inst_valid_o, bus.inst_o, bus.inst_addr_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    do_reset();
    @(negedge clk);
    total++; if ({bus.pc_send_valid_o, bus.pc_o} !== {1'b1, 32'h0}) begin bad++; $display("FAIL seq_first_issue: got v=%b pc=%h want v=1 pc=0", bus.pc_send_valid_o, bus.pc_o); end
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL seq_early_valid: got %b want 0", bus.inst_valid_o); end
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      e = 32'(4 * (c - 1));
      total++; if (bus.pc_o !== e) begin bad++; $display("FAIL seq_pc[%0d]: got %h want %h", c, bus.pc_o, e); end
      if (c == 2) begin
        total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL seq_latency: got valid %b want 0", bus.inst_valid_o); end
      end else begin
        e = 32'(4 * (c - 3));
        total++; if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, e, rom_word(e)}) begin bad++; $display("FAIL seq_out[%0d]: got v=%b a=%h i=%h want a=%h", c, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    bus.inst_ready_i = 1'b0;
    repeat (5) @(negedge clk);
    total++; if ({bus.pc_send_valid_o, bus.pc_o} !== {1'b0, 32'h8}) begin bad++; $display("FAIL bp_full_stall: got v=%b pc=%h want v=0 pc=8", bus.pc_send_valid_o, bus.pc_o); end
    total++; if ({bus.inst_valid_o, bus.inst_addr_o} !== {1'b1, 32'h0}) begin bad++; $display("FAIL bp_head: got v=%b a=%h want v=1 a=0", bus.inst_valid_o, bus.inst_addr_o); end
    bus.inst_ready_i = 1'b1;
    #1;
    total++; if (bus.pc_send_valid_o !== 1'b1) begin bad++; $display("FAIL bp_resume_issue: got %b want 1", bus.pc_send_valid_o); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = 32'(4 * k);
      total++; if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, e, rom_word(e)}) begin bad++; $display("FAIL bp_order[%0d]: got v=%b a=%h i=%h want a=%h", k, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, e); end
    end
  endtask

  task automatic test_jump();
    do_reset();
    repeat (5) @(negedge clk);
    total++; if ({bus.inst_valid_o, bus.inst_addr_o} !== {1'b1, 32'h8}) begin bad++; $display("FAIL jump_pre_head: got v=%b a=%h want a=8", bus.inst_valid_o, bus.inst_addr_o); end
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'h100;
    #1;
    total++; if (bus.pc_send_valid_o !== 1'b0) begin bad++; $display("FAIL jump_no_issue: got %b want 0", bus.pc_send_valid_o); end
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    total++; if ({bus.pc_send_valid_o, bus.pc_o, bus.inst_valid_o} !== {1'b0, 32'h100, 1'b0}) begin bad++; $display("FAIL jump_bubble: got sv=%b pc=%h iv=%b want sv=0 pc=100 iv=0", bus.pc_send_valid_o, bus.pc_o, bus.inst_valid_o); end
    @(negedge clk);
    total++; if ({bus.pc_send_valid_o, bus.pc_o, bus.inst_valid_o} !== {1'b1, 32'h100, 1'b0}) begin bad++; $display("FAIL jump_refetch: got sv=%b pc=%h iv=%b want sv=1 pc=100 iv=0", bus.pc_send_valid_o, bus.pc_o, bus.inst_valid_o); end
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL jump_stale_dropped: got v=%b a=%h want v=0", bus.inst_valid_o, bus.inst_addr_o); end
    @(negedge clk);
    total++; if ({bus.inst_valid_o, bus.inst_addr_o, bus.inst_o} !== {1'b1, 32'h100, rom_word(32'h100)}) begin bad++; $display("FAIL jump_target: got v=%b a=%h i=%h want a=100", bus.inst_valid_o, bus.inst_addr_o, bus.inst_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (3) @(negedge clk);
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'h200;
    @(negedge clk);
    bus.jump_addr_i = 32'h300;
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    total++; if ({bus.pc_send_valid_o, bus.pc_o} !== {1'b0, 32'h300}) begin bad++; $display("FAIL b2b_pc: got v=%b pc=%h want v=0 pc=300", bus.pc_send_valid_o, bus.pc_o); end
    @(negedge clk);
    total++; if ({bus.pc_send_valid_o, bus.pc_o} !== {1'b1, 32'h300}) begin bad++; $display("FAIL b2b_issue: got v=%b pc=%h want v=1 pc=300", bus.pc_send_valid_o, bus.pc_o); end
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_empty: got v=%b a=%h want v=0", bus.inst_valid_o, bus.inst_addr_o); end
    @(negedge clk);
    total++; if ({bus.inst_valid_o, bus.inst_addr_o} !== {1'b1, 32'h300}) begin bad++; $display("FAIL b2b_target: got v=%b a=%h want a=300", bus.inst_valid_o, bus.inst_addr_o); end
  endtask

  task automatic test_rom_stall();
    logic [31:0] e;
    do_reset();
    @(negedge clk);
    bus.pc_receive_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++; if ({bus.pc_send_valid_o, bus.pc_o} !== {1'b1, 32'h0}) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h want v=1 pc=0", k, bus.pc_send_valid_o, bus.pc_o); end
    end
    @(negedge clk);
    bus.pc_receive_ready_i = 1'b1;
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL stall_pc_kept: got %h want 0", bus.pc_o); end
    @(negedge clk);
    total++; if ({bus.pc_o, bus.inst_valid_o} !== {32'h4, 1'b0}) begin bad++; $display("FAIL stall_resume: got pc=%h iv=%b want pc=4 iv=0", bus.pc_o, bus.inst_valid_o); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = 32'(4 * k);
      total++; if ({bus.inst_valid_o, bus.inst_addr_o} !== {1'b1, e}) begin bad++; $display("FAIL stall_seq[%0d]: got v=%b a=%h want a=%h", k, bus.inst_valid_o, bus.inst_addr_o, e); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (3) @(negedge clk);
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    @(negedge clk);
    total++; if ({bus.pc_send_valid_o, bus.pc_o} !== {1'b1, 32'hFFFF_FFFC}) begin bad++; $display("FAIL wrap_top: got v=%b pc=%h want v=1 pc=fffffffc", bus.pc_send_valid_o, bus.pc_o); end
    @(negedge clk);
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 0", bus.pc_o); end
    @(negedge clk);
    total++; if ({bus.inst_valid_o, bus.inst_addr_o, bus.pc_o} !== {1'b1, 32'hFFFF_FFFC, 32'h4}) begin bad++; $display("FAIL wrap_out0: got v=%b a=%h pc=%h want a=fffffffc pc=4", bus.inst_valid_o, bus.inst_addr_o, bus.pc_o); end
    @(negedge clk);
    total++; if ({bus.inst_valid_o, bus.inst_addr_o} !== {1'b1, 32'h0}) begin bad++; $display("FAIL wrap_out1: got v=%b a=%h want a=0", bus.inst_valid_o, bus.inst_addr_o); end
  endtask

  task automatic test_hold();
    do_reset();
    repeat (3) @(negedge clk);
    bus.hold_i = 1'b1;
    #1;
    total++; if ({bus.pc_send_valid_o, bus.inst_valid_o, bus.inst_addr_o} !== {1'b0, 1'b1, 32'h0}) begin bad++; $display("FAIL hold_block: got sv=%b iv=%b a=%h want sv=0 iv=1 a=0", bus.pc_send_valid_o, bus.inst_valid_o, bus.inst_addr_o); end
    @(negedge clk);
    total++; if ({bus.pc_send_valid_o, bus.pc_o, bus.inst_valid_o, bus.inst_addr_o} !== {1'b0, 32'h8, 1'b1, 32'h4}) begin bad++; $display("FAIL hold_capture: got sv=%b pc=%h iv=%b a=%h want sv=0 pc=8 iv=1 a=4", bus.pc_send_valid_o, bus.pc_o, bus.inst_valid_o, bus.inst_addr_o); end
    @(negedge clk);
    total++; if ({bus.inst_valid_o, bus.pc_o} !== {1'b0, 32'h8}) begin bad++; $display("FAIL hold_drained: got iv=%b pc=%h want iv=0 pc=8", bus.inst_valid_o, bus.pc_o); end
    bus.hold_i = 1'b0;
    #1;
    total++; if (bus.pc_send_valid_o !== 1'b1) begin bad++; $display("FAIL hold_release: got %b want 1", bus.pc_send_valid_o); end
  endtask

  task automatic test_midreset();
    do_reset();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    force_valid = 1'b1;
    #1;
    total++; if ({bus.pc_o, bus.pc_send_valid_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o} !== 98'h0) begin bad++; $display("FAIL midreset_clear: got pc=%h sv=%b iv=%b i=%h a=%h want all 0", bus.pc_o, bus.pc_send_valid_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL midreset_ignore: got v=%b want 0", bus.inst_valid_o); end
    force_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL midreset_quiet: got v=%b want 0", bus.inst_valid_o); end
    @(negedge clk);
    total++; if ({bus.inst_valid_o, bus.inst_addr_o} !== {1'b1, 32'h0}) begin bad++; $display("FAIL midreset_restart: got v=%b a=%h want a=0", bus.inst_valid_o, bus.inst_addr_o); end
  endtask

`ifdef IF_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    repeat (5) @(negedge clk);
    total++; if (bus.misalign_o !== 1'b0) begin bad++; $display("FAIL mis_idle: got %b want 0", bus.misalign_o); end
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'h102;
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    total++; if ({bus.misalign_o, bus.pc_o, bus.inst_valid_o} !== {1'b1, 32'h10, 1'b0}) begin bad++; $display("FAIL mis_pulse: got m=%b pc=%h iv=%b want m=1 pc=10 iv=0", bus.misalign_o, bus.pc_o, bus.inst_valid_o); end
    @(negedge clk);
    total++; if ({bus.misalign_o, bus.pc_o} !== {1'b0, 32'h10}) begin bad++; $display("FAIL mis_clear: got m=%b pc=%h want m=0 pc=10", bus.misalign_o, bus.pc_o); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    force_valid = 1'b0;
    bus.jump_en_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.hold_i = 1'b0;
    bus.pc_receive_ready_i = 1'b1;
    bus.inst_ready_i = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump();
    test_back_to_back();
    test_rom_stall();
    test_wrap();
    test_hold();
    test_midreset();
`ifdef IF_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
